// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : Time-multiplexed N-digit 7-segment driver. Captures a packed
//                nibble word plus decimal points, commits it at frame wrap
//                (tear-free), scans one digit per refresh slot with anti-ghost
//                dead time, decodes BCD/hex glyphs and blanks leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 1,
   parameter int HEX_MODE     = 0,
   parameter int SEG_ACT_LOW  = 0,
   parameter int AN_ACT_LOW   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    load_i,
   input  logic                    blank_lz_i,
   output logic [6:0]              seg_o,
   output logic                    dp_out_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_done_o
);

   localparam int c_DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int c_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int c_WORD_W = 5 * NUM_DIGITS;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

   // Word layout for pending/displayed data: {value nibbles, dp bits}
   logic [c_DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [c_IDX_W-1:0]    idx_q, idx_d;
   logic [c_WORD_W-1:0]   pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [c_WORD_W-1:0]   disp_q, disp_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_out_q, dp_out_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_done_q, frame_done_d;

   logic                    w_tick;
   logic                    w_wrap;
   logic                    w_in_blank;
   logic [4*NUM_DIGITS-1:0] w_disp_val;
   logic [NUM_DIGITS-1:0]   w_disp_dp;
   logic [NUM_DIGITS-1:0]   w_lz_vec;
   logic [3:0]              w_nib;
   logic                    w_dp_sel;
   logic                    w_lz;

   assign w_disp_val = disp_q[c_WORD_W-1:NUM_DIGITS];
   assign w_disp_dp  = disp_q[NUM_DIGITS-1:0];

   // Segment pattern {a,b,c,d,e,f,g}, active-high; hex letters optional
   function automatic logic [6:0] f_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b1111110;
         4'h1:    g = 7'b0110000;
         4'h2:    g = 7'b1101101;
         4'h3:    g = 7'b1111001;
         4'h4:    g = 7'b0110011;
         4'h5:    g = 7'b1011011;
         4'h6:    g = 7'b1011111;
         4'h7:    g = 7'b1110000;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1111011;
         4'hA:    g = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
         4'hB:    g = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
         4'hC:    g = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
         4'hD:    g = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
         4'hE:    g = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
         default: g = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
      endcase
      return g;
   endfunction

   // Dead-time window at the start of every slot keeps all anodes off
   generate
      if (BLANK_CYCLES > 0) begin : g_blank_on
         localparam logic [c_DIV_W-1:0] c_BLANK = c_DIV_W'(BLANK_CYCLES);
         assign w_in_blank = (div_cnt_q < c_BLANK);
      end else begin : g_blank_off
         assign w_in_blank = 1'b0;
      end
   endgenerate

   // A digit is a leading zero when it and every more-significant nibble are 0;
   // digit 0 is always shown so a zero value still displays "0"
   assign w_lz_vec[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
         assign w_lz_vec[gi] = (w_disp_val[4*NUM_DIGITS-1:4*gi] == '0);
      end
   endgenerate

   // Divider, scan index, pending capture and tear-free frame commit
   always_comb begin
      w_tick     = (div_cnt_q == c_DIV_LAST);
      w_wrap     = w_tick && (idx_q == c_IDX_LAST);
      div_cnt_d  = w_tick ? '0 : div_cnt_q + c_DIV_ONE;
      idx_d      = idx_q;
      if (w_tick) begin
         idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IDX_ONE;
      end
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (load_i) begin
         pend_d     = {value_i, dp_i};
         pend_vld_d = 1'b1;
      end
      disp_d = disp_q;
      if (w_wrap) begin
         pend_vld_d = 1'b0;
         if (pend_vld_q || load_i) begin
            disp_d = load_i ? {value_i, dp_i} : pend_q;
         end
      end
   end

   // Next pin values derived from the current scan position and display word
   always_comb begin
      w_nib    = '0;
      w_dp_sel = 1'b0;
      w_lz     = 1'b0;
      an_d     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == c_IDX_W'(i)) begin
            w_nib    = w_disp_val[4*i +: 4];
            w_dp_sel = w_disp_dp[i];
            w_lz     = w_lz_vec[i];
            an_d[i]  = !w_in_blank;
         end
      end
      seg_d        = (blank_lz_i && w_lz) ? 7'b0000000 : f_glyph(w_nib);
      dp_out_d     = w_dp_sel;
      frame_done_d = w_wrap;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q    <= '0;
         idx_q        <= '0;
         pend_q       <= '0;
         pend_vld_q   <= 1'b0;
         disp_q       <= '0;
         seg_q        <= '0;
         dp_out_q     <= 1'b0;
         an_q         <= '0;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_vld_q   <= pend_vld_d;
         disp_q       <= disp_d;
         seg_q        <= seg_d;
         dp_out_q     <= dp_out_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Board polarity is applied after the registers so reset reads as "off"
   assign seg_o        = seg_q ^ {7{SEG_ACT_LOW != 0}};
   assign dp_out_o     = dp_out_q ^ (SEG_ACT_LOW != 0);
   assign an_o         = an_q ^ {NUM_DIGITS{AN_ACT_LOW != 0}};
   assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_driver
//  Description : Self-checking bench for seven_seg_scan_driver. Three
//                configurations share one stimulus stream and are compared
//                cycle by cycle against a time-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        blank_lz;
   logic [15:0] value;
   logic [3:0]  dp;

   logic [6:0] seg_a, seg_b, seg_c;
   logic       dpo_a, dpo_b, dpo_c;
   logic [3:0] an_a, an_b;
   logic [0:0] an_c;
   logic       fd_a, fd_b, fd_c;

   always #5 clk = ~clk;

   // Config A: 4 digits, BCD, active-high pins
   seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
      .HEX_MODE(0), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) u_dut_a (
      .clk(clk), .rst(rst), .value_i(value), .dp_i(dp), .load_i(load),
      .blank_lz_i(blank_lz), .seg_o(seg_a), .dp_out_o(dpo_a), .an_o(an_a),
      .frame_done_o(fd_a));

   // Config B: 4 digits, hex glyphs, active-low pins, longer dead time
   seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(5), .BLANK_CYCLES(2),
      .HEX_MODE(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) u_dut_b (
      .clk(clk), .rst(rst), .value_i(value), .dp_i(dp), .load_i(load),
      .blank_lz_i(blank_lz), .seg_o(seg_b), .dp_out_o(dpo_b), .an_o(an_b),
      .frame_done_o(fd_b));

   // Config C: single digit, no dead time, active-low anode only
   seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .BLANK_CYCLES(0),
      .HEX_MODE(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(1)) u_dut_c (
      .clk(clk), .rst(rst), .value_i(value[3:0]), .dp_i(dp[0:0]), .load_i(load),
      .blank_lz_i(blank_lz), .seg_o(seg_c), .dp_out_o(dpo_c), .an_o(an_c),
      .frame_done_o(fd_c));

   localparam int P_N     [3] = '{4, 4, 1};
   localparam int P_DIV   [3] = '{4, 5, 3};
   localparam int P_BLANK [3] = '{1, 2, 0};
   localparam int P_HEX   [3] = '{0, 1, 1};
   localparam int P_SAL   [3] = '{0, 1, 0};
   localparam int P_AAL   [3] = '{0, 1, 1};

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: cycles since reset, committed and latest-loaded words
   int          m_cyc     [3];
   logic [15:0] m_disp_v  [3];
   logic [3:0]  m_disp_dp [3];
   logic [15:0] m_pend_v  [3];
   logic [3:0]  m_pend_dp [3];
   bit          m_have    [3];

   function automatic logic [6:0] ref_glyph(input int nib, input int hex);
      case (nib)
         0:  return 7'b1111110;
         1:  return 7'b0110000;
         2:  return 7'b1101101;
         3:  return 7'b1111001;
         4:  return 7'b0110011;
         5:  return 7'b1011011;
         6:  return 7'b1011111;
         7:  return 7'b1110000;
         8:  return 7'b1111111;
         9:  return 7'b1111011;
         10: return (hex != 0) ? 7'b1110111 : 7'b0000000;
         11: return (hex != 0) ? 7'b0011111 : 7'b0000000;
         12: return (hex != 0) ? 7'b1001110 : 7'b0000000;
         13: return (hex != 0) ? 7'b0111101 : 7'b0000000;
         14: return (hex != 0) ? 7'b1001111 : 7'b0000000;
         default: return (hex != 0) ? 7'b1000111 : 7'b0000000;
      endcase
   endfunction

   task automatic check(input string tag, input int d, input logic [6:0] obs,
                        input logic [6:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, d, m_cyc[d], obs, exp);
      end
   endtask

   // One clock: predict outputs from pre-edge state, clock, advance model, compare
   task automatic step();
      logic [6:0]  e_seg [3];
      logic [6:0]  e_an  [3];
      logic        e_dp  [3];
      logic        e_fd  [3];
      logic [6:0]  o_seg [3];
      logic [6:0]  o_an  [3];
      logic        o_dp  [3];
      logic        o_fd  [3];
      bit          wrap  [3];
      for (int d = 0; d < 3; d++) begin
         int n, dv, pos, dig, nib;
         logic [15:0] upper;
         n   = P_N[d];
         dv  = P_DIV[d];
         pos = m_cyc[d] % dv;
         dig = (m_cyc[d] / dv) % n;
         wrap[d] = (pos == dv - 1) && (dig == n - 1);
         if (rst) begin
            e_seg[d] = '0; e_an[d] = '0; e_dp[d] = 1'b0; e_fd[d] = 1'b0;
         end else begin
            upper    = m_disp_v[d] >> (4 * dig);
            nib      = int'(upper & 16'h000F);
            e_an[d]  = (pos < P_BLANK[d]) ? 7'd0 : 7'(1 << dig);
            e_seg[d] = (blank_lz && dig > 0 && upper == 16'h0) ? 7'd0
                                                               : ref_glyph(nib, P_HEX[d]);
            e_dp[d]  = m_disp_dp[d][dig];
            e_fd[d]  = wrap[d];
         end
         if (P_SAL[d] != 0) begin
            e_seg[d] = e_seg[d] ^ 7'h7F;
            e_dp[d]  = ~e_dp[d];
         end
         if (P_AAL[d] != 0) e_an[d] = e_an[d] ^ 7'((1 << n) - 1);
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         logic [15:0] mv;
         logic [3:0]  md;
         mv = (P_N[d] == 4) ? 16'hFFFF : 16'h000F;
         md = (P_N[d] == 4) ? 4'hF : 4'h1;
         if (rst) begin
            m_cyc[d] = 0; m_have[d] = 0;
            m_disp_v[d] = '0; m_disp_dp[d] = '0;
         end else begin
            if (load) begin
               m_pend_v[d] = value & mv; m_pend_dp[d] = dp & md; m_have[d] = 1;
            end
            if (wrap[d]) begin
               if (m_have[d]) begin
                  m_disp_v[d] = m_pend_v[d]; m_disp_dp[d] = m_pend_dp[d];
               end
               m_have[d] = 0;
            end
            m_cyc[d]++;
         end
      end
      #1;
      o_seg[0] = seg_a; o_an[0] = 7'(an_a); o_dp[0] = dpo_a; o_fd[0] = fd_a;
      o_seg[1] = seg_b; o_an[1] = 7'(an_b); o_dp[1] = dpo_b; o_fd[1] = fd_b;
      o_seg[2] = seg_c; o_an[2] = 7'(an_c); o_dp[2] = dpo_c; o_fd[2] = fd_c;
      for (int d = 0; d < 3; d++) begin
         check("seg", d, o_seg[d], e_seg[d]);
         check("an", d, o_an[d], e_an[d]);
         check("dp_out", d, 7'(o_dp[d]), 7'(e_dp[d]));
         check("frame_done", d, 7'(o_fd[d]), 7'(e_fd[d]));
      end
   endtask

   task automatic run(input int cycles);
      for (int k = 0; k < cycles; k++) step();
   endtask

   task automatic load_word(input logic [15:0] v, input logic [3:0] p);
      value = v; dp = p; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         m_cyc[d] = 0; m_have[d] = 0;
         m_disp_v[d] = '0; m_disp_dp[d] = '0; m_pend_v[d] = '0; m_pend_dp[d] = '0;
      end
      rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0; dp = '0;
      #2;
      // Reset held three cycles, then free-running scan of the all-zero word
      run(3);
      rst = 1'b0;
      run(24);
      // Decode of BCD digits with one decimal point
      load_word(16'h1234, 4'b0100);
      run(45);
      // Hex letters: blank on the BCD config, glyphs on the hex configs
      load_word(16'hABCD, 4'b1001);
      run(45);
      // Two loads inside one frame: only the last appears, and only after wrap
      load_word(16'h1111, 4'b0000);
      run(5);
      load_word(16'h2222, 4'b0011);
      run(45);
      // Load exactly on the wrap cycle of config A
      for (int k = 0; k < 64 && !((m_cyc[0] % 4 == 3) && ((m_cyc[0] / 4) % 4 == 3)); k++)
         step();
      load_word(16'h5678, 4'b1000);
      run(20);
      // Leading-zero blanking
      blank_lz = 1'b1;
      load_word(16'h0070, 4'b0000);
      run(45);
      load_word(16'h0000, 4'b0100);
      run(45);
      // Reset in the middle of a frame while config A shows digit 2
      load_word(16'h9876, 4'b1111);
      run(20);
      for (int k = 0; k < 64 && ((m_cyc[0] / 4) % 4 != 2); k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(40);
      // Randomized traffic with occasional resets and blanking toggles
      for (int i = 0; i < 800; i++) begin
         int sel;
         sel   = $urandom_range(0, 3);
         value = 16'($urandom) & ((sel == 0) ? 16'h000F : (sel == 1) ? 16'h00FF :
                                  (sel == 2) ? 16'h0FFF : 16'hFFFF);
         dp    = 4'($urandom);
         load  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         rst   = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0; load = 1'b0;
      run(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
